// File: rtl/store_pkg.sv
// store_pkg: shared FSM state and error-code definitions for the store unit.
package store_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;
   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_RANGE  = 2'b01;
   localparam logic [1:0] ERR_VERIFY = 2'b10;
endpackage

// File: rtl/store_mem.sv
// store_mem: data memory with one synchronous write port and two range-gated async read ports.
module store_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] vaddr,
   output logic [DATA_W-1:0] vdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);
   logic [DATA_W-1:0] mem [DEPTH];
   // Contents are deliberately never reset.
   always_ff @(posedge clk)
      if (we && {1'b0, waddr} < DEP) mem[waddr[AW-1:0]] <= wdata;
   always_comb begin
      vdata = {1'b0, vaddr} < DEP ? mem[vaddr[AW-1:0]] : '0;
      rdata = {1'b0, raddr} < DEP ? mem[raddr[AW-1:0]] : '0;
   end
endmodule

// File: rtl/store_unit.sv
// store_unit: multi-cycle M[X] <- AC store with start/busy/done handshake,
// address range checking and optional read-back verification.
module store_unit import store_pkg::*; #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int DEPTH  = 4096,
   parameter int VERIFY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] x,
   input  logic [DATA_W-1:0] ac,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] mar,
   output logic [DATA_W-1:0] mbr,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);
   state_t state, nxt;
   logic [DATA_W-1:0] vdata;
   logic in_rng, we;
   store_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
      .clk(clk), .we(we), .waddr(mar), .wdata(mbr),
      .vaddr(mar), .vdata(vdata), .raddr(rd_addr), .rdata(rd_data)
   );
   always_comb begin
      in_rng = {1'b0, mar} < DEP;
      we     = state == S_WRITE && in_rng;
      busy   = state != S_IDLE;
      done   = state == S_DONE;
      nxt    = state == S_IDLE   ? (start ? S_WRITE : S_IDLE) :
               state == S_WRITE  ? ((in_rng && VERIFY != 0) ? S_VERIFY : S_DONE) :
               state == S_VERIFY ? S_DONE : S_IDLE;
   end
   // MAR and MBR load on the same edge so MBR can never hold a stale AC.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= S_IDLE;
         mar      <= '0;
         mbr      <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         state <= nxt;
         if (state == S_IDLE && start) begin
            mar      <= x;
            mbr      <= ac;
            err      <= 1'b0;
            err_code <= ERR_NONE;
         end
         if (state == S_WRITE && !in_rng) begin
            err      <= 1'b1;
            err_code <= ERR_RANGE;
         end
         if (state == S_VERIFY && vdata != mbr) begin
            err      <= 1'b1;
            err_code <= ERR_VERIFY;
         end
      end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized scoreboard bench for store_unit against a word-array reference model.
module tb_store_unit;
   typedef struct {
      logic [11:0] a;
      logic [15:0] d;
      logic [1:0]  ec;
      int          t;
      int          lat;
   } item_t;

   logic clk = 0, rst = 1, start1 = 0, start0 = 0;
   logic [11:0] x = 0, rd_addr = 0;
   logic [15:0] ac = 0;
   logic busy1, done1, err1, busy0, done0, err0;
   logic [1:0] ec1, ec0;
   logic [11:0] mar1, mar0;
   logic [15:0] mbr1, mbr0, rd1, rd0;
   int cyc = 0, nchk = 0, nfail = 0;
   item_t q1[$], q0[$];
   logic [15:0] ref1 [int];

   store_unit #(.DATA_W(16), .ADDR_W(12), .DEPTH(2048), .VERIFY(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .x(x), .ac(ac), .busy(busy1), .done(done1),
      .err(err1), .err_code(ec1), .mar(mar1), .mbr(mbr1), .rd_addr(rd_addr), .rd_data(rd1));
   store_unit #(.DATA_W(16), .ADDR_W(12), .DEPTH(4096), .VERIFY(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .x(x), .ac(ac), .busy(busy0), .done(done0),
      .err(err0), .err_code(ec0), .mar(mar0), .mbr(mbr0), .rd_addr(rd_addr), .rd_data(rd0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   always @(negedge clk) if (!rst && done1) begin
      item_t it;
      if (q1.size() == 0) chk("unexpected done1", {31'd0, done1}, 0);
      else begin
         it = q1.pop_front();
         chk("lat1", cyc - it.t + 1, it.lat);
         chk("err1", {31'd0, err1}, {31'd0, it.ec != 2'b00});
         chk("ec1", {30'd0, ec1}, {30'd0, it.ec});
         chk("mar1", {20'd0, mar1}, {20'd0, it.a});
         chk("mbr1", {16'd0, mbr1}, {16'd0, it.d});
         chk("busy1 in done", {31'd0, busy1}, 1);
      end
   end

   always @(negedge clk) if (!rst && done0) begin
      item_t it;
      if (q0.size() == 0) chk("unexpected done0", {31'd0, done0}, 0);
      else begin
         it = q0.pop_front();
         chk("lat0", cyc - it.t + 1, it.lat);
         chk("ec0", {30'd0, ec0}, {30'd0, it.ec});
         chk("mbr0", {16'd0, mbr0}, {16'd0, it.d});
      end
   end

   task automatic wait_idle1();
      int n = 0;
      @(negedge clk);
      while (busy1 && n < 20) begin @(negedge clk); n++; end
      chk("idle1", {31'd0, busy1}, 0);
   endtask

   function automatic item_t expect1(logic [11:0] a, logic [15:0] d, bit flip);
      item_t it;
      bit ok = a < 2048;
      it.a = a; it.d = d; it.t = 0;
      it.ec = !ok ? 2'b01 : flip ? 2'b10 : 2'b00;
      it.lat = ok ? 3 : 2;
      return it;
   endfunction

   // Issue one store on dut1; optionally corrupt the read-back word during S_VERIFY.
   task automatic store1(logic [11:0] a, logic [15:0] d, bit flip);
      item_t it = expect1(a, d, flip);
      wait_idle1();
      x = a; ac = d; start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      it.t = cyc;
      q1.push_back(it);
      if (a < 2048) ref1[int'(a)] = d;
      if (flip && a < 2048) begin
         @(posedge clk); #1;
         force dut1.vdata = ~d;
         @(posedge clk); #1;
         release dut1.vdata;
      end
   endtask

   task automatic chk_rd1(logic [11:0] a);
      rd_addr = a; #1;
      if (a >= 2048) chk("rd1 oob", {16'd0, rd1}, 0);
      else if (ref1.exists(int'(a))) chk("rd1", {16'd0, rd1}, {16'd0, ref1[int'(a)]});
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      item_t it;
      repeat (2) @(negedge clk);
      chk("rst busy", {31'd0, busy1}, 0);
      chk("rst done", {31'd0, done1}, 0);
      chk("rst err", {31'd0, err1}, 0);
      chk("rst ec", {30'd0, ec1}, 0);
      chk("rst mar", {20'd0, mar1}, 0);
      chk("rst mbr", {16'd0, mbr1}, 0);
      rst = 0;
      // basic store and readback
      store1(12'h010, 16'hBEEF, 0);
      chk("busy after accept", {31'd0, busy1}, 1);
      wait_idle1(); chk_rd1(12'h010);
      // out-of-range store; error is sticky in idle
      store1(12'h900, 16'h5555, 0);
      wait_idle1(); repeat (2) @(negedge clk);
      chk("sticky err", {31'd0, err1}, 1);
      chk("sticky ec", {30'd0, ec1}, 2'b01);
      chk_rd1(12'h900);
      // back-to-back with start held high
      wait_idle1();
      x = 12'h005; ac = 16'h1111; start1 = 1;
      @(posedge clk); #1;
      it = expect1(12'h005, 16'h1111, 0); it.t = cyc; q1.push_back(it); ref1[5] = 16'h1111;
      ac = 16'h2222;
      repeat (3) @(posedge clk);
      @(posedge clk); #1;
      it = expect1(12'h005, 16'h2222, 0); it.t = cyc; q1.push_back(it); ref1[5] = 16'h2222;
      start1 = 0;
      wait_idle1(); chk_rd1(12'h005);
      // start pulse while busy is ignored
      store1(12'h040, 16'h4040, 0);
      x = 12'h020; ac = 16'hDEAD; start1 = 1;
      @(posedge clk); #1; start1 = 0;
      wait_idle1(); repeat (2) @(negedge clk);
      chk("ignored busy1", {31'd0, busy1}, 0);
      chk_rd1(12'h020); chk_rd1(12'h040);
      rd_addr = 12'h020; #1;
      if (!ref1.exists(32'h020)) chk("ignored write", {16'd0, rd1}, {16'd0, rd1 == 16'hDEAD ? 16'h0000 : rd1});
      // reset during S_WRITE aborts the store
      store1(12'h030, 16'h1234, 0);
      store1(12'hA00, 16'h0BAD, 0);
      wait_idle1();
      x = 12'h030; ac = 16'hFFFF; start1 = 1;
      @(posedge clk); #1; start1 = 0; rst = 1;
      @(posedge clk); #1;
      chk("abort busy", {31'd0, busy1}, 0);
      chk("abort done", {31'd0, done1}, 0);
      chk("abort err", {31'd0, err1}, 0);
      chk("abort ec", {30'd0, ec1}, 0);
      chk("abort mar", {20'd0, mar1}, 0);
      chk("abort mbr", {16'd0, mbr1}, 0);
      rst = 0;
      chk_rd1(12'h030);
      // forced verify mismatch
      store1(12'h066, 16'hA5A5, 1);
      wait_idle1(); chk_rd1(12'h066);
      // randomized stores
      for (int i = 0; i < 40; i++) begin
         logic [11:0] a = $urandom_range(0, 1) ? 12'($urandom_range(0, 15)) : 12'($urandom_range(0, 4095));
         store1(a, 16'($urandom), a < 2048 && $urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 1)) begin wait_idle1(); chk_rd1(12'($urandom_range(0, 15))); end
      end
      wait_idle1();
      for (int a = 0; a < 16; a++) chk_rd1(12'(a));
      // VERIFY=0, full-depth instance
      x = 12'hFFF; ac = 16'h0001; start0 = 1;
      @(posedge clk); #1; start0 = 0;
      it.a = 12'hFFF; it.d = 16'h0001; it.ec = 2'b00; it.t = cyc; it.lat = 2; q0.push_back(it);
      repeat (4) @(negedge clk);
      x = 12'h800; ac = 16'h8888; start0 = 1;
      @(posedge clk); #1; start0 = 0;
      it.a = 12'h800; it.d = 16'h8888; it.t = cyc; q0.push_back(it);
      repeat (4) @(negedge clk);
      rd_addr = 12'hFFF; #1; chk("rd0 fff", {16'd0, rd0}, 16'h0001);
      rd_addr = 12'h800; #1; chk("rd0 800", {16'd0, rd0}, 16'h8888);
      chk("err0", {31'd0, err0}, 0);
      repeat (4) @(negedge clk);
      chk("q1 drained", q1.size(), 0);
      chk("q0 drained", q0.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
